// File: rtl/memwb_lsu.sv
// Memory-access / writeback stage: issues req/gnt/rvalid bus transactions for loads and stores,
// aligns load data and drives the register-file write port for ALU and load results.
module memwb_lsu #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_w_reg_enable_i,
    input  logic          mem_w_reg_enable_i,
    input  logic [4:0]    w_reg_addr_i,
    input  logic [DW-1:0] ex_w_reg_data_i,
    input  logic          w_mem_enable_i,
    input  logic [AW-1:0] w_mem_addr_i,
    input  logic [DW-1:0] w_mem_data_i,
    input  logic          r_mem_enable_i,
    input  logic [AW-1:0] r_mem_addr_i,
    input  logic [2:0]    data_type_i,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [3:0]    bus_be_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic          bus_gnt_i,
    input  logic          bus_rvalid_i,
    input  logic [DW-1:0] bus_rdata_i,
    output logic          hold_req_o,
    output logic          misalign_o,
    output logic          wb_en_o,
    output logic [4:0]    wb_addr_o,
    output logic [DW-1:0] wb_data_o
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e        state_q, state_d;

    logic          we_q;
    logic          wen_q;
    logic [4:0]    rd_q;
    logic [2:0]    type_q;
    logic [1:0]    off_q;

    logic          type_ok, is_store, is_load, mem_op, aligned, go, misalign;
    logic [AW-1:0] req_addr;
    logic [3:0]    be_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] shifted, load_data;

    // Request decode; a store wins when both enables are set.
    always_comb begin
        type_ok  = (data_type_i <= 3'd4);
        is_store = w_mem_enable_i && type_ok;
        is_load  = r_mem_enable_i && !w_mem_enable_i && type_ok;
        mem_op   = is_store || is_load;
        req_addr = is_store ? w_mem_addr_i : r_mem_addr_i;
        case (data_type_i)
            3'd0:        aligned = (req_addr[1:0] == 2'b00);
            3'd1, 3'd2:  aligned = !req_addr[0];
            default:     aligned = 1'b1;
        endcase
        go       = mem_op && aligned;
        misalign = mem_op && !aligned;
    end

    always_comb begin
        case (data_type_i)
            3'd0: begin
                be_d    = 4'b1111;
                wdata_d = w_mem_data_i;
            end
            3'd1, 3'd2: begin
                be_d    = 4'b0011 << req_addr[1:0];
                wdata_d = {2{w_mem_data_i[15:0]}};
            end
            default: begin
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {4{w_mem_data_i[7:0]}};
            end
        endcase
    end

    always_comb begin
        shifted = bus_rdata_i >> {off_q, 3'b000};
        case (type_q)
            3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'd2:    load_data = {16'h0000, shifted[15:0]};
            3'd3:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd4:    load_data = {24'h000000, shifted[7:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (go) state_d = StReq;
            StReq:   if (bus_gnt_i) state_d = we_q ? StIdle : StResp;
            StResp:  if (bus_rvalid_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Hold drops in the cycle the access completes so upstream advances on that edge.
    always_comb begin
        hold_req_o = 1'b0;
        case (state_q)
            StIdle:  hold_req_o = go;
            StReq:   hold_req_o = !(bus_gnt_i && we_q);
            StResp:  hold_req_o = !bus_rvalid_i;
            default: hold_req_o = 1'b0;
        endcase
        hold_req_o = hold_req_o && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            wen_q       <= 1'b0;
            rd_q        <= '0;
            type_q      <= '0;
            off_q       <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            misalign_o  <= 1'b0;
            wb_en_o     <= 1'b0;
            wb_addr_o   <= '0;
            wb_data_o   <= '0;
        end else begin
            wb_en_o    <= 1'b0;
            misalign_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (go) begin
                        we_q        <= is_store;
                        wen_q       <= mem_w_reg_enable_i;
                        rd_q        <= w_reg_addr_i;
                        type_q      <= data_type_i;
                        off_q       <= req_addr[1:0];
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_store;
                        bus_addr_o  <= {req_addr[AW-1:2], 2'b00};
                        bus_be_o    <= be_d;
                        bus_wdata_o <= wdata_d;
                    end else if (misalign) begin
                        misalign_o <= 1'b1;
                    end else if (ex_w_reg_enable_i) begin
                        wb_en_o   <= (w_reg_addr_i != 5'd0);
                        wb_addr_o <= w_reg_addr_i;
                        wb_data_o <= ex_w_reg_data_i;
                    end
                end
                StReq: begin
                    if (bus_gnt_i) bus_req_o <= 1'b0;
                end
                StResp: begin
                    if (bus_rvalid_i && wen_q) begin
                        wb_en_o   <= (rd_q != 5'd0);
                        wb_addr_o <= rd_q;
                        wb_data_o <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memwb_lsu.sv
// Directed and randomized bench for memwb_lsu; a reference model derives lanes, strobes,
// alignment and extended load values from the access size and byte offset.
module tb_memwb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_w, mem_w, w_en, r_en;
    logic [4:0]  rd;
    logic [31:0] ex_data, w_addr, w_data, r_addr;
    logic [2:0]  dtype;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        hold, misalign, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_vec = 0;
    int n_err = 0;

    memwb_lsu #(.AW(32), .DW(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ex_w_reg_enable_i  (ex_w),
        .mem_w_reg_enable_i (mem_w),
        .w_reg_addr_i       (rd),
        .ex_w_reg_data_i    (ex_data),
        .w_mem_enable_i     (w_en),
        .w_mem_addr_i       (w_addr),
        .w_mem_data_i       (w_data),
        .r_mem_enable_i     (r_en),
        .r_mem_addr_i       (r_addr),
        .data_type_i        (dtype),
        .bus_req_o          (bus_req),
        .bus_we_o           (bus_we),
        .bus_addr_o         (bus_addr),
        .bus_be_o           (bus_be),
        .bus_wdata_o        (bus_wdata),
        .bus_gnt_i          (bus_gnt),
        .bus_rvalid_i       (bus_rvalid),
        .bus_rdata_i        (bus_rdata),
        .hold_req_o         (hold),
        .misalign_o         (misalign),
        .wb_en_o            (wb_en),
        .wb_addr_o          (wb_addr),
        .wb_data_o          (wb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int tsize(input logic [2:0] t);
        if (t == 3'd0) return 4;
        if (t == 3'd1 || t == 3'd2) return 2;
        return 1;
    endfunction

    function automatic bit m_legal(input logic [2:0] t, input logic [31:0] a);
        return (a % tsize(t)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
        int s = tsize(t);
        return 4'(((1 << s) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
        int s = tsize(t);
        if (s == 1) return (d % 256) * 32'h0101_0101;
        if (s == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] rdata);
        logic [31:0] v = rdata / (32'd1 << (8 * (a % 4)));
        if (t == 3'd3 || t == 3'd4) begin
            v = v % 256;
            if (t == 3'd3 && v >= 128) v = v - 256;
        end else if (t == 3'd1 || t == 3'd2) begin
            v = v % 65536;
            if (t == 3'd1 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic clear_inputs();
        ex_w = 0; mem_w = 0; w_en = 0; r_en = 0; rd = 0; ex_data = 0;
        w_addr = 0; w_data = 0; r_addr = 0; dtype = 3'd7;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        clear_inputs();
        #1 check("idle_hold", 32'(hold), 0);
        @(posedge clk); #1;
        check("idle_req", 32'(bus_req), 0);
        check("idle_wb_en", 32'(wb_en), 0);
        check("idle_misalign", 32'(misalign), 0);
    endtask

    task automatic do_alu(input logic [4:0] rdi, input logic [31:0] d);
        @(negedge clk);
        clear_inputs();
        ex_w = 1; rd = rdi; ex_data = d;
        #1 check("alu_hold", 32'(hold), 0);
        @(posedge clk); #1;
        check("alu_wb_en", 32'(wb_en), 32'(rdi != 0));
        if (rdi != 0) begin
            check("alu_wb_addr", 32'(wb_addr), 32'(rdi));
            check("alu_wb_data", wb_data, d);
        end
        check("alu_req", 32'(bus_req), 0);
    endtask

    // kind: 0 store, 1 load, 2 both enables (behaves as store)
    task automatic do_mem(input int kind, input logic [2:0] t, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata, input int gd,
                          input int rvd, input logic mw, input logic [4:0] rdi);
        bit store = (kind != 1);
        bit legal = m_legal(t, addr);
        @(negedge clk);
        clear_inputs();
        ex_w = 1'($urandom); ex_data = $urandom;
        mem_w = mw; rd = rdi; dtype = t; w_data = data;
        w_en = store; r_en = (kind != 0);
        w_addr = store ? addr : $urandom;
        r_addr = store ? $urandom : addr;
        #1 check("idle_hold_mem", 32'(hold), 32'(legal));
        @(posedge clk); #1;
        if (!legal) begin
            check("misalign_pulse", 32'(misalign), 1);
            check("misalign_req", 32'(bus_req), 0);
            check("misalign_wb", 32'(wb_en), 0);
            idle_cycle();
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            @(negedge clk);
            bus_gnt = (k == gd);
            #1;
            check("req_valid", 32'(bus_req), 1);
            check("req_we", 32'(bus_we), 32'(store));
            check("req_addr", bus_addr, addr & 32'hFFFF_FFFC);
            check("req_be", 32'(bus_be), 32'(m_be(t, addr)));
            if (store) check("req_wdata", bus_wdata, m_wdata(t, data));
            check("req_hold", 32'(hold), 32'(!(store && k == gd)));
            check("req_wb", 32'(wb_en), 0);
            @(posedge clk); #1;
        end
        check("req_dropped", 32'(bus_req), 0);
        if (store) begin
            check("store_no_wb", 32'(wb_en), 0);
            return;
        end
        for (int j = 0; j <= rvd; j++) begin
            @(negedge clk);
            bus_gnt = 1'($urandom);
            bus_rvalid = (j == rvd);
            bus_rdata = (j == rvd) ? rdata : $urandom;
            #1;
            check("resp_hold", 32'(hold), 32'(j != rvd));
            check("resp_req", 32'(bus_req), 0);
            @(posedge clk); #1;
            if (j < rvd) check("resp_wb_early", 32'(wb_en), 0);
        end
        check("load_wb_en", 32'(wb_en), 32'(mw && rdi != 0));
        if (mw && rdi != 0) begin
            check("load_wb_addr", 32'(wb_addr), 32'(rdi));
            check("load_wb_data", wb_data, m_load(t, addr, rdata));
        end
    endtask

    task automatic reset_mid(input bit in_resp);
        @(negedge clk);
        clear_inputs();
        r_en = 1; r_addr = 32'h400; dtype = 3'd0; mem_w = 1; rd = 5'd7;
        @(posedge clk);
        if (in_resp) begin
            @(negedge clk);
            bus_gnt = 1;
            @(posedge clk);
        end
        @(negedge clk);
        bus_gnt = 0;
        #1 check("pre_reset_hold", 32'(hold), 1);
        check("pre_reset_req", 32'(bus_req), 32'(!in_resp));
        #1 rst_n = 0;
        #1;
        check("rst_mid_req", 32'(bus_req), 0);
        check("rst_mid_hold", 32'(hold), 0);
        check("rst_mid_wb", 32'(wb_en), 0);
        @(posedge clk); #1;
        check("rst_hold_req", 32'(bus_req), 0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1;
        idle_cycle();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus_req), 0);
        check("rst_we", 32'(bus_we), 0);
        check("rst_addr", bus_addr, 0);
        check("rst_be", 32'(bus_be), 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_misalign", 32'(misalign), 0);
        check("rst_wb_en", 32'(wb_en), 0);
        check("rst_wb_addr", 32'(wb_addr), 0);
        check("rst_wb_data", wb_data, 0);
        r_en = 1; dtype = 3'd0; r_addr = 32'h10;
        #1 check("rst_hold", 32'(hold), 0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1;
        idle_cycle();

        do_alu(5'd5, 32'h1234);
        do_alu(5'd0, 32'hCAFE);
        do_mem(0, 3'd0, 32'h100, 32'hDEAD_BEEF, 0, 3, 0, 0, 5'd9);
        do_mem(1, 3'd3, 32'h203, 0, 32'h80FF_FF7F, 1, 2, 1, 5'd10);
        do_mem(1, 3'd4, 32'h203, 0, 32'h80FF_FF7F, 0, 0, 1, 5'd11);
        do_mem(1, 3'd1, 32'h201, 0, 0, 0, 0, 1, 5'd12);
        do_mem(0, 3'd3, 32'h302, 32'h0000_00AB, 0, 0, 0, 0, 5'd0);
        do_mem(2, 3'd2, 32'h306, 32'h1234_5678, 0, 1, 0, 1, 5'd13);
        do_mem(1, 3'd1, 32'h502, 0, 32'h8001_7FFF, 0, 1, 1, 5'd14);
        do_mem(1, 3'd0, 32'h600, 0, 32'h1357_9BDF, 2, 0, 1, 5'd0);
        reset_mid(1'b1);
        reset_mid(1'b0);

        for (int i = 0; i < 80; i++) begin
            int          sel = $urandom_range(0, 3);
            logic [2:0]  t   = 3'($urandom_range(0, 4));
            logic [31:0] a   = $urandom;
            if (sel == 3) do_alu(5'($urandom), $urandom);
            else do_mem(sel, t, a, $urandom, $urandom, $urandom_range(0, 3),
                        $urandom_range(0, 3), 1'($urandom), 5'($urandom));
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
